// File: rtl/led_share_pkg.sv
// Shared types and constants for the LED time-share scheduler.
package led_share_pkg;

   localparam int LED_W = 8;
   localparam int NREQ  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   function automatic logic [LED_W-1:0] onehot_led(input logic [2:0] pos);
      return LED_W'(1) << pos;
   endfunction

endpackage

// File: rtl/led_share_sched_if.sv
// Requester-side handshake bundle: request levels, patterns and grants.
interface led_share_sched_if;

   logic [led_share_pkg::NREQ-1:0]  req;
   logic [led_share_pkg::LED_W-1:0] pat0;
   logic [led_share_pkg::LED_W-1:0] pat1;
   logic [led_share_pkg::NREQ-1:0]  gnt;

   modport master (output req, output pat0, output pat1, input  gnt);
   modport slave  (input  req, input  pat0, input  pat1, output gnt);

endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: one-cycle tick every DIV clocks, free-running out of reset.
module led_tick_gen #(
   parameter int DIV = 1200000
) (
   input  logic clk,
   input  logic rstn,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Down-counter loaded with DIV-1; terminal count at zero gives the tick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= LOAD;
      end else if (cnt == '0) begin
         cnt <= LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/led_share_sched.sv
// Time-shares the 8 user LEDs between two requesters; bouncing scanner when idle.
//
// state | meaning
// IDLE  | no owner, LEDs show the one-hot scanner
// G0    | requester 0 owns the LEDs (pat0)
// G1    | requester 1 owns the LEDs (pat1)
module led_share_sched
   import led_share_pkg::*;
#(
   parameter int DIV        = 1200000,
   parameter int HOLD_STEPS = 4
) (
   input  logic             clk,
   input  logic             rstn,
   led_share_sched_if.slave bus,
   output logic             LED0,
   output logic             LED1,
   output logic             LED2,
   output logic             LED3,
   output logic             LED4,
   output logic             LED5,
   output logic             LED6,
   output logic             LED7
);

   localparam int            SW         = $clog2(HOLD_STEPS) + 1;
   localparam logic [SW-1:0] SLICE_LAST = SW'(HOLD_STEPS - 1);

   state_t           state;
   state_t           state_nxt;
   logic             tick;
   logic             ptr;
   logic [2:0]       pos;
   logic             dir_dn;
   logic [SW-1:0]    slice;
   logic             slice_end;
   logic [LED_W-1:0] led;
   logic [LED_W-1:0] led_src;

   led_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .tick (tick)
   );

   assign slice_end = tick && (slice == SLICE_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bus.gnt   = '0;
      led_src   = onehot_led(pos);
      case (state)
         IDLE: begin
            case (bus.req)
               2'b01:   state_nxt = G0;
               2'b10:   state_nxt = G1;
               2'b11:   state_nxt = ptr ? G0 : G1;
               default: state_nxt = IDLE;
            endcase
         end
         G0: begin
            bus.gnt = 2'b01;
            led_src = bus.pat0;
            if (!bus.req[0]) begin
               state_nxt = bus.req[1] ? G1 : IDLE;
            end else if (bus.req[1] && slice_end) begin
               state_nxt = G1;
            end
         end
         G1: begin
            bus.gnt = 2'b10;
            led_src = bus.pat1;
            if (!bus.req[1]) begin
               state_nxt = bus.req[0] ? G0 : IDLE;
            end else if (bus.req[0] && slice_end) begin
               state_nxt = G0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pointer holds the most recent owner so a tie from IDLE goes to the other one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr <= 1'b1;
      end else if (state_nxt != state) begin
         if (state_nxt == G0) begin
            ptr <= 1'b0;
         end else if (state_nxt == G1) begin
            ptr <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slice <= '0;
      end else if (state_nxt != state) begin
         slice <= '0;
      end else if ((state != IDLE) && tick && (slice != SLICE_LAST)) begin
         slice <= slice + 1'b1;
      end
   end

   // Scanner only advances in IDLE, so it resumes where it froze.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pos    <= 3'd0;
         dir_dn <= 1'b0;
      end else if ((state == IDLE) && tick) begin
         if (!dir_dn) begin
            if (pos == 3'd7) begin
               pos    <= 3'd6;
               dir_dn <= 1'b1;
            end else begin
               pos <= pos + 3'd1;
            end
         end else begin
            if (pos == 3'd0) begin
               pos    <= 3'd1;
               dir_dn <= 1'b0;
            end else begin
               pos <= pos - 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led <= '0;
      end else begin
         led <= led_src;
      end
   end

   assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led;

endmodule
